fx_div: RTL and testbench

Sequential sign-magnitude fixed-point divider for the stepper datapath, using the same Q/N sign-magnitude format as the fixed-point adder. It computes the quotient by restoring division (repeated trial subtraction), one quotient bit per clock. It serves ramp and step-interval calculations that need dividing one fixed-point quantity by another without a large combinational array. Operation uses a start/done handshake, and results are held until the next start.

---
 rtl/fx_div.sv | 108 ++++++++++
 tb/tb_fx_div.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fx_div.sv
// Sequential sign-magnitude fixed-point divider (restoring, one quotient bit per clock).
// Quotient saturates on overflow or divide-by-zero; results hold until the next accepted start.
module fx_div #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         start_in,
  input  logic [N-1:0] dividend_in,
  input  logic [N-1:0] divisor_in,
  output logic         busy_out,
  output logic         done_out,
  output logic [N-1:0] quotient_out,
  output logic         overflow_out,
  output logic         div_by_zero_out
);
  localparam int FW = N - 1 + Q;
  localparam int CW = $clog2(FW + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] num, quo;
  logic [N-1:0]  rem;
  logic [N-2:0]  dvs;
  logic          sgn;
  logic [CW-1:0] cnt;

  logic          dvs_zero_in;
  logic [N-1:0]  rem_sh, rem_nxt;
  logic          take;
  logic [FW-1:0] quo_sh;
  logic          ovf_c;
  logic [N-2:0]  mag_c;

  assign dvs_zero_in = (divisor_in[N-2:0] == '0);

  // One restoring step; the trial compare never loses bits since rem < dvs before the shift.
  assign rem_sh  = {rem[N-2:0], num[FW-1]};
  assign take    = (rem_sh >= {1'b0, dvs});
  assign rem_nxt = take ? (rem_sh - {1'b0, dvs}) : rem_sh;
  assign quo_sh  = {quo[FW-2:0], take};
  assign ovf_c   = |quo_sh[FW-1:N-1];
  assign mag_c   = ovf_c ? '1 : quo_sh[N-2:0];

  assign busy_out = (state == CALC);
  assign done_out = (state == DONE);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_in) state_nxt = dvs_zero_in ? DONE : CALC;
      CALC: if (cnt == CW'(1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      num             <= '0;
      quo             <= '0;
      rem             <= '0;
      dvs             <= '0;
      sgn             <= 1'b0;
      cnt             <= '0;
      quotient_out    <= '0;
      overflow_out    <= 1'b0;
      div_by_zero_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_in) begin
          if (dvs_zero_in) begin
            // Saturated magnitude is never zero, so the XOR sign always stands.
            quotient_out    <= {dividend_in[N-1] ^ divisor_in[N-1], {(N-1){1'b1}}};
            overflow_out    <= 1'b0;
            div_by_zero_out <= 1'b1;
          end else begin
            num <= {dividend_in[N-2:0], {Q{1'b0}}};
            quo <= '0;
            rem <= '0;
            dvs <= divisor_in[N-2:0];
            sgn <= dividend_in[N-1] ^ divisor_in[N-1];
            cnt <= CW'(FW);
          end
        end
        CALC: begin
          num <= {num[FW-2:0], 1'b0};
          rem <= rem_nxt;
          quo <= quo_sh;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quotient_out    <= {sgn & (|mag_c), mag_c};
            overflow_out    <= ovf_c;
            div_by_zero_out <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fx_div.sv
// Directed bench for fx_div: a scoreboard queue of expected results from a behavioural
// model, popped and checked with immediate assertions when done_out pulses.
module tb_fx_div;
  localparam int Q = 15;
  localparam int N = 32;

  typedef struct packed {
    logic [N-1:0] q;
    logic         ovf;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy, done, ovf, dz;
  logic [N-1:0] quotient;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  fx_div #(.Q(Q), .N(N)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start),
    .dividend_in(dividend), .divisor_in(divisor),
    .busy_out(busy), .done_out(done), .quotient_out(quotient),
    .overflow_out(ovf), .div_by_zero_out(dz)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t        r;
    logic [63:0] qf;
    logic [N-2:0] mag;
    if (b[N-2:0] == '0) begin
      r.q   = {a[N-1] ^ b[N-1], {(N-1){1'b1}}};
      r.ovf = 1'b0;
      r.dz  = 1'b1;
    end else begin
      qf    = ({33'b0, a[N-2:0]} << Q) / {33'b0, b[N-2:0]};
      r.ovf = (qf >> (N - 1)) != 0;
      mag   = r.ovf ? '1 : qf[N-2:0];
      r.q   = {(a[N-1] ^ b[N-1]) & (mag != '0), mag};
      r.dz  = 1'b0;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Latency counts negedge samples after the start edge: the first sample is 1.
  task automatic wait_done(input string tag, input int exp_lat, output bit saw_busy);
    int lat;
    lat = 0;
    saw_busy = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) saw_busy = 1;
      if (done) break;
    end
    chk({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_quotient"}, quotient, e.q);
    chk({tag, "_overflow"}, ovf, e.ovf);
    chk({tag, "_div0"}, dz, e.dz);
  endtask

  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
    bit saw_busy;
    bit zero;
    zero = (b[N-2:0] == '0);
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1 start = 1'b0; dividend = $urandom; divisor = $urandom;
    wait_done(tag, zero ? 1 : N + Q, saw_busy);
    check_result(tag);
    chk({tag, "_busy_seen"}, saw_busy, !zero);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    bit sb_busy;
    logic [N-1:0] held;

    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_flags", {ovf, dz}, 0);
    @(negedge clk); rst_n = 1'b1;

    chk("model_3_div_1p5", model(32'h00018000, 32'h0000C000), {32'h00010000, 2'b00});

    run_div(32'h00018000, 32'h0000C000, "pos_3_div_1p5");
    run_div(32'h80018000, 32'h0000C000, "neg_3_div_1p5");
    run_div(32'h00008000, 32'h00018000, "one_third");
    chk("one_third_value", quotient, 32'h00002AAA);
    run_div(32'h7FFFFFFF, 32'h00000001, "overflow");
    chk("overflow_value", {ovf, quotient}, {1'b1, 32'h7FFFFFFF});
    run_div(32'h80000000, 32'h00008000, "neg_zero");
    chk("neg_zero_value", quotient, 32'h00000000);
    run_div(32'h80008000, 32'h80000000, "div0");
    chk("div0_value", {dz, ovf, quotient}, {2'b10, 32'h7FFFFFFF});

    // Results hold through idle cycles.
    held = quotient;
    repeat (5) @(negedge clk);
    chk("hold_idle", {dz, quotient}, {1'b1, held});

    // Second start during CALC must not disturb the first division.
    sb.push_back(model(32'h00030000, 32'h00008000));
    @(negedge clk);
    start = 1'b1; dividend = 32'h00030000; divisor = 32'h00008000;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1; dividend = 32'h00008000; divisor = 32'h00030000;
    @(negedge clk);
    start = 1'b0;
    begin
      int lat;
      lat = 11;
      while (lat < 200 && !done) begin @(negedge clk); lat++; end
      chk("ignore_calc_latency", lat, N + Q);
    end
    check_result("ignore_calc");

    // Start held from DONE: ignored in DONE, accepted on the first IDLE edge.
    sb.push_back(model(32'h00008000, 32'h00010000));
    start = 1'b1; dividend = 32'h00008000; divisor = 32'h00010000;
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("first_idle", N + Q, sb_busy);
    check_result("first_idle");
    chk("first_idle_value", quotient, 32'h00004000);

    // Reset in the middle of CALC aborts with no done pulse.
    @(negedge clk);
    start = 1'b1; dividend = 32'h00018000; divisor = 32'h0000C000;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {busy, done, ovf, dz, quotient}, 0);
    begin
      bit saw_done;
      saw_done = 0;
      repeat (5) begin @(negedge clk); if (done || busy) saw_done = 1; end
      rst_n = 1'b1;
      repeat (40) begin @(negedge clk); if (done || busy) saw_done = 1; end
      chk("midreset_no_done", saw_done, 0);
    end
    run_div(32'h00018000, 32'h0000C000, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout observed=hang expected=finish");
    $fatal(1, "timeout");
  end
endmodule
